// File: rtl/bus_master_8088_if.sv
// Request/response handshake plus 8088 bus control and address pins for bus_master_8088.
// The bidirectional data bus is a plain inout port on the module, outside this interface.
interface bus_master_8088_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_io;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              ready;
    logic              ale;
    logic              iom;
    logic              rd;
    logic              wr;
    logic              den;
    logic              dtr;
    logic [ADDR_W-1:0] addr;

    modport master (
        input  req_valid, req_write, req_io, req_addr, req_wdata, ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               ale, iom, rd, wr, den, dtr, addr
    );

    modport slave (
        output req_valid, req_write, req_io, req_addr, req_wdata, ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               ale, iom, rd, wr, den, dtr, addr
    );
endinterface

// File: rtl/bus_master_8088.sv
// 8088 bus-cycle generator: one request at a time through T1,T2,T3,[TW..],T4 then TI idle cycles.
// Optional BUS_TIMEOUT_EN aborts after TIMEOUT_CYCLES wait states with rsp_err.
module bus_master_8088 #(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 8,
    parameter int TI_CYCLES      = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    bus_master_8088_if.master   io_bus,
    inout  wire  [DATA_W-1:0]   io_data
);
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4, S_TI} state_t;

    localparam int TIW = (TI_CYCLES > 1) ? $clog2(TI_CYCLES) : 1;

    state_t            r_state;
    state_t            w_state_nx;
    logic [TIW-1:0]    r_ti_cnt;
    logic              r_write;
    logic              r_io;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_req_ready;
    logic              r_ale;
    logic              r_rd;
    logic              r_wr;
    logic              r_den;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              w_hs;
    logic              w_timeout;
    logic              w_strobe_nx;
    logic              w_data_oe;

    assign w_hs = io_bus.req_valid & r_req_ready;

`ifdef BUS_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] r_tw_cnt;
    logic           r_rsp_err;

    // Fires during the last allowed TW so the bus leaves after exactly TIMEOUT_CYCLES wait states.
    assign w_timeout = (r_state == S_TW) && !io_bus.ready &&
                       (r_tw_cnt == TOW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tw_cnt  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == S_T1)
                r_tw_cnt <= '0;
            else if (r_state == S_TW)
                r_tw_cnt <= r_tw_cnt + TOW'(1);
            r_rsp_err <= w_timeout;
        end
    end

    assign io_bus.rsp_err = r_rsp_err;
`else
    assign w_timeout      = 1'b0;
    assign io_bus.rsp_err = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:     if (w_hs) w_state_nx = S_T1;
            S_T1:       w_state_nx = S_T2;
            S_T2:       w_state_nx = S_T3;
            S_T3, S_TW: w_state_nx = (io_bus.ready || w_timeout) ? S_T4 : S_TW;
            S_T4:       w_state_nx = S_TI;
            S_TI:       if (r_ti_cnt == TIW'(TI_CYCLES - 1)) w_state_nx = S_IDLE;
            default:    w_state_nx = S_IDLE;
        endcase
    end

    assign w_strobe_nx = (w_state_nx == S_T2) || (w_state_nx == S_T3) || (w_state_nx == S_TW);

    // Pin registers load from the next state so every strobe lines up with its T-state cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ti_cnt    <= '0;
            r_write     <= 1'b0;
            r_io        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b0;
            r_ale       <= 1'b0;
            r_rd        <= 1'b1;
            r_wr        <= 1'b1;
            r_den       <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_hs) begin
                r_write <= io_bus.req_write;
                r_io    <= io_bus.req_io;
                r_addr  <= io_bus.req_addr;
                r_wdata <= io_bus.req_wdata;
            end
            r_ti_cnt    <= (r_state == S_TI) ? r_ti_cnt + TIW'(1) : '0;
            r_req_ready <= (w_state_nx == S_IDLE);
            r_ale       <= (w_state_nx == S_T1);
            r_den       <= !w_strobe_nx;
            r_rd        <= !(w_strobe_nx && !r_write);
            r_wr        <= !(w_strobe_nx && r_write);
            r_rsp_valid <= (w_state_nx == S_T4);
            if (w_state_nx == S_T4)
                r_rsp_rdata <= (r_write || w_timeout) ? '0 : io_data;
        end
    end

    assign w_data_oe = r_write && ((r_state == S_T2) || (r_state == S_T3) ||
                                   (r_state == S_TW) || (r_state == S_T4));
    assign io_data   = w_data_oe ? r_wdata : {DATA_W{1'bz}};

    assign io_bus.req_ready = r_req_ready;
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_rdata = r_rsp_rdata;
    assign io_bus.ale       = r_ale;
    assign io_bus.iom       = r_io;
    assign io_bus.rd        = r_rd;
    assign io_bus.wr        = r_wr;
    assign io_bus.den       = r_den;
    assign io_bus.dtr       = r_write;
    assign io_bus.addr      = r_addr;
endmodule

// File: tb/tb_bus_master_8088.sv
// Bench for bus_master_8088: small memory/IO slave model plus a scoreboard of expected responses.
module tb_bus_master_8088;
    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 8;
    localparam int TI_CYCLES = 1;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    exp_t sb[$];
    int   acc_cyc;
    int   lat, n_ale, n_rd, n_wr, n_wd, n_iom, n_viol, n_rdy;
    bit   got;
    logic [7:0] t4_data;
    logic       t4_dtr;
    logic [7:0] mem [0:31];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_master_8088_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    wire [DATA_W-1:0] io_data;

    bus_master_8088 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TI_CYCLES(TI_CYCLES)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus),
        .io_data (io_data)
    );

    // Slave: index is {iom, addr[3:0]}; drives while rd is low, stores while wr is low.
    assign io_data = (!bus.rd) ? mem[{bus.iom, bus.addr[3:0]}] : 8'hzz;
    always @(posedge clk) if (!bus.wr) mem[{bus.iom, bus.addr[3:0]}] = io_data;

    task automatic issue(input bit w, input bit io, input logic [19:0] a, input logic [7:0] d,
                         input logic [7:0] er, input bit ee);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_io    = io;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept: req_ready=%b required 1 within 50 cycles", bus.req_ready);
        end
        acc_cyc = cyc;
        sb.push_back('{er, ee});
    endtask

    task automatic wait_rsp(input int ws, input bit keep_valid, input logic [7:0] wd,
                            input logic [7:0] late);
        int k;
        exp_t e;
        got = 0; lat = -1; n_ale = 0; n_rd = 0; n_wr = 0; n_wd = 0; n_iom = 0; n_viol = 0; n_rdy = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (!keep_valid) bus.req_valid = 1'b0;
            k = cyc - acc_cyc;
            bus.ready = !(k >= 3 && k < 3 + ws);
            if (ws > 0 && k == 3 + ws) mem[{bus.iom, bus.addr[3:0]}] = late;
            if (bus.ale) n_ale++;
            if (!bus.rd) n_rd++;
            if (!bus.wr) begin
                n_wr++;
                if (io_data === wd) n_wd++;
            end
            if (bus.iom) n_iom++;
            if (bus.req_ready) n_rdy++;
            if ((!bus.rd && !bus.wr) || (bus.ale && (!bus.rd || !bus.wr))) n_viol++;
            if (bus.rsp_valid) begin
                got = 1; lat = k; t4_data = io_data; t4_dtr = bus.dtr;
            end
        end
        bus.ready = 1'b1;
        tests_run++;
        if (!got || sb.size() == 0) begin
            tests_failed++;
            $display("FAIL rsp_timeout: got=%0d sb=%0d required a response within 200 cycles",
                     got, sb.size());
        end else begin
            e = sb.pop_front();
            tests_run++;
            if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                tests_failed++;
                $display("FAIL rsp_data: rdata=%h err=%b required rdata=%h err=%b",
                         bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.ale !== 1'b0 || bus.iom !== 1'b0 || bus.dtr !== 1'b0 || bus.addr !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_addr: ale=%b iom=%b dtr=%b addr=%h required 0 0 0 00000",
                     bus.ale, bus.iom, bus.dtr, bus.addr);
        end
        tests_run++;
        if (bus.rd !== 1'b1 || bus.wr !== 1'b1 || bus.den !== 1'b1 || dut.w_data_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: rd=%b wr=%b den=%b oe=%b required 1 1 1 0",
                     bus.rd, bus.wr, bus.den, dut.w_data_oe);
        end
        tests_run++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 8'h00 ||
            bus.rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hs: req_ready=%b rsp_valid=%b rdata=%h err=%b required 0 0 00 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: req_ready=%b required 1", bus.req_ready);
        end
    endtask

    task automatic test_mem_read();
        issue(1'b0, 1'b0, 20'h00010, 8'h00, 8'hA5, 1'b0);
        wait_rsp(0, 1'b0, 8'h00, 8'h00);
        tests_run++;
        if (lat != 4 || n_ale != 1 || n_rd != 2 || n_wr != 0 || n_iom != 0 || n_viol != 0) begin
            tests_failed++;
            $display("FAIL mem_read_timing: lat=%0d ale=%0d rd=%0d wr=%0d iom=%0d viol=%0d required 4 1 2 0 0 0",
                     lat, n_ale, n_rd, n_wr, n_iom, n_viol);
        end
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rsp_pulse: rsp_valid=%b one cycle after T4, required 0", bus.rsp_valid);
        end
    endtask

    task automatic test_io_write();
        issue(1'b1, 1'b1, 20'h0FF04, 8'h3C, 8'h00, 1'b0);
        wait_rsp(0, 1'b0, 8'h3C, 8'h00);
        tests_run++;
        if (lat != 4 || n_wr != 2 || n_wd != 2 || n_rd != 0 || n_iom != 4 || n_viol != 0) begin
            tests_failed++;
            $display("FAIL io_write_timing: lat=%0d wr=%0d wd=%0d rd=%0d iom=%0d viol=%0d required 4 2 2 0 4 0",
                     lat, n_wr, n_wd, n_rd, n_iom, n_viol);
        end
        tests_run++;
        if (t4_data !== 8'h3C || t4_dtr !== 1'b1) begin
            tests_failed++;
            $display("FAIL io_write_t4: data=%h dtr=%b required 3c 1", t4_data, t4_dtr);
        end
        issue(1'b0, 1'b1, 20'h0FF04, 8'h00, 8'h3C, 1'b0);
        wait_rsp(0, 1'b0, 8'h00, 8'h00);
        tests_run++;
        if (lat != 4 || n_iom != 4 || n_rd != 2) begin
            tests_failed++;
            $display("FAIL io_readback_timing: lat=%0d iom=%0d rd=%0d required 4 4 2", lat, n_iom, n_rd);
        end
    endtask

    task automatic test_wait_states();
        // Slave data changes on the cycle ready rises, so only the late sample sees 8'hC7.
        issue(1'b0, 1'b0, 20'h00013, 8'h00, 8'hC7, 1'b0);
        wait_rsp(3, 1'b0, 8'h00, 8'hC7);
        tests_run++;
        if (lat != 7 || n_rd != 5 || n_ale != 1 || n_viol != 0) begin
            tests_failed++;
            $display("FAIL wait_states: lat=%0d rd=%0d ale=%0d viol=%0d required 7 5 1 0",
                     lat, n_rd, n_ale, n_viol);
        end
    endtask

    task automatic test_back_to_back();
        int t4_cyc;
        issue(1'b0, 1'b0, 20'h00010, 8'h00, 8'hA5, 1'b0);
        wait_rsp(0, 1'b1, 8'h00, 8'h00);
        t4_cyc = cyc;
        tests_run++;
        if (n_rdy != 0) begin
            tests_failed++;
            $display("FAIL b2b_ready: req_ready high %0d cycles during transfer, required 0", n_rdy);
        end
        issue(1'b0, 1'b0, 20'h00013, 8'h00, 8'hC7, 1'b0);
        tests_run++;
        if ((acc_cyc + 1) - t4_cyc < TI_CYCLES + 1) begin
            tests_failed++;
            $display("FAIL b2b_gap: second T1 %0d cycles after T4, required at least %0d",
                     (acc_cyc + 1) - t4_cyc, TI_CYCLES + 1);
        end
        wait_rsp(0, 1'b0, 8'h00, 8'h00);
        tests_run++;
        if (lat != 4 || n_rdy != 0) begin
            tests_failed++;
            $display("FAIL b2b_second: lat=%0d rdy=%0d required 4 0", lat, n_rdy);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int spur = 0;
        issue(1'b1, 1'b0, 20'h00017, 8'h77, 8'h00, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (cyc - acc_cyc < 3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (bus.wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_t3: wr=%b in T3 of write, required 0", bus.wr);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.wr !== 1'b1 || bus.den !== 1'b1 || dut.w_data_oe !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: wr=%b den=%b oe=%b rsp_valid=%b required 1 1 0 0",
                     bus.wr, bus.den, dut.w_data_oe, bus.rsp_valid);
        end
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) spur++;
        end
        tests_run++;
        if (spur != 0) begin
            tests_failed++;
            $display("FAIL mid_no_rsp: %0d responses after abort, required 0", spur);
        end
        issue(1'b0, 1'b0, 20'h00010, 8'h00, 8'hA5, 1'b0);
        wait_rsp(0, 1'b0, 8'h00, 8'h00);
        tests_run++;
        if (lat != 4 || n_ale != 1 || n_rd != 2) begin
            tests_failed++;
            $display("FAIL mid_recover: lat=%0d ale=%0d rd=%0d required 4 1 2", lat, n_ale, n_rd);
        end
    endtask

    task automatic test_timeout();
`ifdef BUS_TIMEOUT_EN
        issue(1'b0, 1'b0, 20'h00010, 8'h00, 8'h00, 1'b1);
        wait_rsp(25, 1'b0, 8'h00, 8'hA5);
        tests_run++;
        if (lat != 20 || n_rd != 18) begin
            tests_failed++;
            $display("FAIL timeout: lat=%0d rd=%0d required 20 18", lat, n_rd);
        end
`else
        issue(1'b0, 1'b0, 20'h00010, 8'h00, 8'hA5, 1'b0);
        wait_rsp(25, 1'b0, 8'h00, 8'hA5);
        tests_run++;
        if (lat != 29 || n_rd != 27) begin
            tests_failed++;
            $display("FAIL long_wait: lat=%0d rd=%0d required 29 27", lat, n_rd);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'hFF;
        mem[0] = 8'hA5;
        mem[3] = 8'h5E;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_io    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.ready     = 1'b1;
        test_reset();
        test_mem_read();
        test_io_write();
        test_wait_states();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
